// File: rtl/mul_arbiter_pkg.sv
// rtl/mul_arbiter_pkg.sv - shared types and constants for the two-requester multiplier arbiter
package mul_arbiter_pkg;

    localparam int W_DEF = 4;
    localparam int ID_W  = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester and result handshake bundle
interface mul_arbiter_if
    import mul_arbiter_pkg::*;
#(
    parameter int W = W_DEF
);
    logic               req0_valid;
    logic               req0_ready;
    logic [W-1:0]       req0_a;
    logic [W-1:0]       req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [W-1:0]       req1_a;
    logic [W-1:0]       req1_b;
    logic               res_valid;
    logic               res_ready;
    logic [2*W-1:0]     res_p;
    logic [ID_W-1:0]    res_id;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_p, res_id
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_p, res_id
    );
endinterface

// File: rtl/mul_arbiter_mul_core.sv
// rtl/mul_arbiter_mul_core.sv - combinational unsigned shift-and-add array multiplier
module mul_core #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                p = p + ({{W{1'b0}}, a} << i);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter feeding one shared multiplier, one result in flight
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_arbiter_if.slave bus,
    output logic        busy
);

    state_t             state_q;
    logic               last_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [ID_W-1:0]    id_q;
    logic [2*W-1:0]     p_q;
    logic               res_valid_q;
    logic               busy_q;
    logic [2*W-1:0]     prod_d;
    logic               gnt0_d;
    logic               gnt1_d;

    // With both pending, last_q (the previous winner) hands the turn to the other side.
    assign gnt0_d = bus.req0_valid && (!bus.req1_valid || last_q);
    assign gnt1_d = bus.req1_valid && (!bus.req0_valid || !last_q);

    assign bus.req0_ready = rst_n && (state_q == S_IDLE) && gnt0_d;
    assign bus.req1_ready = rst_n && (state_q == S_IDLE) && gnt1_d;

    assign bus.res_valid = res_valid_q;
    assign bus.res_p     = p_q;
    assign bus.res_id    = id_q;
    assign busy          = busy_q;

    mul_core #(.W(W)) u_mul_core (
        .a (a_q),
        .b (b_q),
        .p (prod_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            p_q         <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req0_valid && bus.req0_ready) begin
                        a_q     <= bus.req0_a;
                        b_q     <= bus.req0_b;
                        id_q    <= '0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_MUL;
                    end else if (bus.req1_valid && bus.req1_ready) begin
                        a_q     <= bus.req1_a;
                        b_q     <= bus.req1_b;
                        id_q    <= ID_W'(1);
                        last_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    p_q         <= prod_d;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: W, default 4, unsigned operand width; product width is 2*W.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester has operands pending.
REQ-005 req0_ready / req1_ready  output  1 each  operand accept strobe for that requester.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W each  unsigned operands of each requester.
REQ-007 res_valid  output  1  result held on res_p/res_id.
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 res_p  output  2*W  unsigned product.
REQ-010 res_id  output  1  index of the requester that owns res_p.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, MUL, RESP; encoding free, one register.
REQ-013 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in the same cycle, capture its a/b and id into operand registers, and move to MUL.
REQ-014 A request is accepted only on a cycle where reqN_valid and reqN_ready are both high.
REQ-015 reqN_ready is low in MUL and RESP; it is never high for both requesters in the same cycle.
REQ-016 Arbitration is round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-017 The last-grant register updates only on an accepted request.
REQ-018 MUL: one cycle; registers the full 2*W product of the captured operands from the shared multiplier core; moves to RESP.
REQ-019 RESP: res_valid=1 with res_p and res_id stable; on res_ready=1 move to IDLE; otherwise hold all values indefinitely.
REQ-020 Latency: acceptance at cycle N gives res_valid at cycle N+2; minimum throughput is one result per 3 cycles.
REQ-021 No new request is accepted in the RESP cycle where res_ready is high; acceptance resumes in the following IDLE cycle.
REQ-022 Arithmetic: res_p = a*b exact, unsigned, no truncation; (2^W-1)^2 fits in 2*W bits.
REQ-023 reqN_valid dropping while not granted is legal, and no request is lost or duplicated for that requester.
REQ-024 res_valid is low in IDLE and MUL.

Reset
REQ-025 On rst_n=0, regardless of state: FSM goes to IDLE, any in-flight transaction is discarded, and last-grant is set to 1 so requester 0 wins the first tie.
REQ-026 Reset values: res_valid=0, res_p=0, res_id=0, busy=0, operand registers=0.
REQ-027 While rst_n=0, req0_ready and req1_ready are 0.
REQ-028 Deassertion of rst_n is synchronised externally, and the first acceptance can occur on the first edge after release.

Structure
REQ-029 A shared package holds the FSM state typedef, the default W constant, and the requester-id width constant.
REQ-030 The multiplier is one sub-module, mul_core (parameter W, purely combinational unsigned array multiplier, inputs a/b, output p of 2*W), instantiated once.
REQ-031 The arbiter, FSM and output registers live in mul_arbiter.

Verification
REQ-032 Single request: req0 a=4'hF, b=4'hF, res_ready=1 -> req0_ready same cycle; res_valid two cycles later with res_p=8'hE1, res_id=0; busy back to 0 after the handshake.
REQ-033 Simultaneous requests after reset: both valid, req0 (3,5), req1 (7,9) -> first result 15, id 0; second result 63, id 1; never two ready strobes in one cycle.
REQ-034 Backpressure: res_ready=0 for 5 cycles in RESP -> res_valid, res_p and res_id held constant; req ready stays 0; result accepted on the cycle res_ready rises.
REQ-035 Fairness: both requesters valid continuously for 8 transactions -> grants alternate 0,1,0,1...; each requester receives exactly 4 results with correct products.
REQ-036 Reset mid-operation: assert rst_n=0 during MUL with req1 (6,6) in flight -> all outputs at reset values immediately; no result for (6,6) after release; the next tie grants requester 0.
REQ-037 Exhaustive: every a,b in 0..15 through req1 -> res_p equals a*b for all 256 pairs; zero operands give 8'h00.
